// File: rtl/core_mul_ctrl.sv
// Sequencer between the core control unit and the iterative core_mul datapath:
// issues one multiply, waits for the product, writes it back and updates N/Z.
module core_mul_ctrl #(
   parameter int W       = 32,
   parameter int MAX_CYC = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [2:0]   req_op,
   input  logic         req_s,
   input  logic [W-1:0] req_rm,
   input  logic [W-1:0] req_rs,
   input  logic [W-1:0] req_acc_hi,
   input  logic [W-1:0] req_acc_lo,
   input  logic [3:0]   req_rd_lo,
   input  logic [3:0]   req_rd_hi,
   input  logic         flush,
   output logic         mul_start,
   output logic [W-1:0] mul_a,
   output logic [W-1:0] mul_b,
   output logic [W-1:0] mul_c_hi,
   output logic [W-1:0] mul_c_lo,
   output logic         mul_c_size,
   output logic         mul_add,
   output logic         mul_sig,
   output logic         mul_q_size,
   input  logic         mul_rdy,
   input  logic [W-1:0] mul_q_hi,
   input  logic [W-1:0] mul_q_lo,
   output logic         wr_en,
   input  logic         wr_ready,
   output logic [3:0]   wr_reg,
   output logic [W-1:0] wr_value,
   output logic         flags_we,
   output logic         flag_n,
   output logic         flag_z,
   output logic         busy,
   output logic         err
);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT, WB_LO, WB_HI, DRAIN
   } state_t;

   localparam int CW = $clog2(MAX_CYC);

   state_t         state, state_nx;
   logic [CW-1:0]  cnt;
   logic           long_q, s_q;
   logic [3:0]     rd_lo_q, rd_hi_q;
   logic [W-1:0]   q_hi_q, q_lo_q;
   logic           accept, legal, timeout, err_nx;

   assign req_ready = (state == IDLE) & ~flush;
   assign accept    = req_valid & req_ready;
   assign legal     = (req_op[2:1] != 2'b01);
   assign busy      = (state != IDLE);
   // cnt is 0 on the first WAIT cycle, so this is MAX_CYC-1 cycles after start
   assign timeout   = (cnt == CW'(MAX_CYC - 2));

   assign flag_n = flags_we & (long_q ? q_hi_q[W-1] : q_lo_q[W-1]);
   assign flag_z = flags_we & (long_q ? ~|{q_hi_q, q_lo_q} : ~|q_lo_q);

   always_comb begin
      state_nx  = state;
      mul_start = 1'b0;
      wr_en     = 1'b0;
      wr_reg    = '0;
      wr_value  = '0;
      flags_we  = 1'b0;
      err_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (legal) state_nx = ISSUE;
               else       err_nx   = 1'b1;
            end
         end
         ISSUE: begin
            mul_start = 1'b1;
            state_nx  = flush ? DRAIN : WAIT;
         end
         WAIT: begin
            if (mul_rdy) begin
               state_nx = flush ? IDLE : WB_LO;
            end else if (timeout) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
            end else if (flush) begin
               state_nx = DRAIN;
            end
         end
         WB_LO: begin
            wr_reg   = rd_lo_q;
            wr_value = q_lo_q;
            if (flush) begin
               state_nx = IDLE;
            end else begin
               wr_en = 1'b1;
               if (wr_ready) begin
                  state_nx = long_q ? WB_HI : IDLE;
                  flags_we = s_q & ~long_q;
               end
            end
         end
         WB_HI: begin
            wr_reg   = rd_hi_q;
            wr_value = q_hi_q;
            if (flush) begin
               state_nx = IDLE;
            end else begin
               wr_en = 1'b1;
               if (wr_ready) begin
                  state_nx = IDLE;
                  flags_we = s_q;
               end
            end
         end
         DRAIN: begin
            if (mul_rdy) begin
               state_nx = IDLE;
            end else if (timeout) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         err        <= 1'b0;
         cnt        <= '0;
         mul_a      <= '0;
         mul_b      <= '0;
         mul_c_hi   <= '0;
         mul_c_lo   <= '0;
         mul_c_size <= 1'b0;
         mul_q_size <= 1'b0;
         mul_add    <= 1'b0;
         mul_sig    <= 1'b0;
         long_q     <= 1'b0;
         s_q        <= 1'b0;
         rd_lo_q    <= '0;
         rd_hi_q    <= '0;
         q_hi_q     <= '0;
         q_lo_q     <= '0;
      end else begin
         state <= state_nx;
         err   <= err_nx;
         if (accept) begin
            mul_a      <= req_rm;
            mul_b      <= req_rs;
            mul_c_hi   <= req_op[2] ? req_acc_hi : '0;
            mul_c_lo   <= req_acc_lo;
            mul_c_size <= req_op[2];
            mul_q_size <= req_op[2];
            mul_add    <= req_op[0];
            mul_sig    <= req_op[2] & req_op[1];
            long_q     <= req_op[2];
            s_q        <= req_s;
            rd_lo_q    <= req_rd_lo;
            rd_hi_q    <= req_rd_hi;
         end
         if (state == ISSUE)
            cnt <= '0;
         else if (state == WAIT || state == DRAIN)
            cnt <= cnt + CW'(1);
         if (state == WAIT && mul_rdy) begin
            q_hi_q <= mul_q_hi;
            q_lo_q <= mul_q_lo;
         end
      end
   end

endmodule

// File: tb/tb_core_mul_ctrl.sv
// Directed bench for core_mul_ctrl; the bench plays the role of core_mul
// and the regfile port, with hand-computed products and write sequences.
module tb_core_mul_ctrl;

   localparam int W       = 32;
   localparam int MAX_CYC = 40;

   logic         clk, rst;
   logic         req_valid, req_ready;
   logic [2:0]   req_op;
   logic         req_s;
   logic [W-1:0] req_rm, req_rs, req_acc_hi, req_acc_lo;
   logic [3:0]   req_rd_lo, req_rd_hi;
   logic         flush;
   logic         mul_start;
   logic [W-1:0] mul_a, mul_b, mul_c_hi, mul_c_lo;
   logic         mul_c_size, mul_add, mul_sig, mul_q_size;
   logic         mul_rdy;
   logic [W-1:0] mul_q_hi, mul_q_lo;
   logic         wr_en, wr_ready;
   logic [3:0]   wr_reg;
   logic [W-1:0] wr_value;
   logic         flags_we, flag_n, flag_z, busy, err;

   int vectors;
   int miscompares;

   core_mul_ctrl #(.W(W), .MAX_CYC(MAX_CYC)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_s(req_s),
      .req_rm(req_rm), .req_rs(req_rs),
      .req_acc_hi(req_acc_hi), .req_acc_lo(req_acc_lo),
      .req_rd_lo(req_rd_lo), .req_rd_hi(req_rd_hi),
      .flush(flush),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_c_hi(mul_c_hi), .mul_c_lo(mul_c_lo),
      .mul_c_size(mul_c_size), .mul_add(mul_add),
      .mul_sig(mul_sig), .mul_q_size(mul_q_size),
      .mul_rdy(mul_rdy), .mul_q_hi(mul_q_hi), .mul_q_lo(mul_q_lo),
      .wr_en(wr_en), .wr_ready(wr_ready),
      .wr_reg(wr_reg), .wr_value(wr_value),
      .flags_we(flags_we), .flag_n(flag_n), .flag_z(flag_z),
      .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = 3'b000;
      req_s      = 1'b0;
      req_rm     = '0;
      req_rs     = '0;
      req_acc_hi = '0;
      req_acc_lo = '0;
      req_rd_lo  = '0;
      req_rd_hi  = '0;
      flush      = 1'b0;
      mul_rdy    = 1'b0;
      mul_q_hi   = '0;
      mul_q_lo   = '0;
      wr_ready   = 1'b1;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_start", mul_start, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_err", err, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_flags_we", flags_we, 0);
      nxt();
      rst = 1'b0;

      // MUL 7*6, S=1; a mul_rdy during ISSUE must be ignored
      nxt();
      req_valid = 1'b1; req_op = 3'b000; req_s = 1'b1;
      req_rm = 7; req_rs = 6; req_acc_hi = 32'h55; req_acc_lo = 0;
      req_rd_lo = 3; req_rd_hi = 9;
      #1 chk("mul_ready", req_ready, 1);
      nxt();
      req_valid = 1'b0; mul_rdy = 1'b1; mul_q_lo = 99;
      #1;
      chk("mul_start", mul_start, 1);
      chk("mul_a", mul_a, 7);
      chk("mul_b", mul_b, 6);
      chk("mul_c_size", mul_c_size, 0);
      chk("mul_c_hi", mul_c_hi, 0);
      chk("mul_busy", busy, 1);
      nxt();
      mul_rdy = 1'b0; req_rm = 100;
      #1;
      chk("mul_start_off", mul_start, 0);
      chk("mul_issue_rdy_ign", wr_en, 0);
      nxt();
      mul_rdy = 1'b1; mul_q_lo = 42; mul_q_hi = 0;
      #1 chk("mul_a_hold", mul_a, 7);
      nxt();
      mul_rdy = 1'b0;
      #1;
      chk("mul_wr_en", wr_en, 1);
      chk("mul_wr_reg", wr_reg, 3);
      chk("mul_wr_val", wr_value, 42);
      chk("mul_flags_we", flags_we, 1);
      chk("mul_n", flag_n, 0);
      chk("mul_z", flag_z, 0);
      nxt();
      #1;
      chk("mul_busy_end", busy, 0);
      chk("mul_wr_end", wr_en, 0);
      chk("mul_fwe_end", flags_we, 0);
      chk("mul_ready_end", req_ready, 1);

      // SMULL 0xFFFFFFFF*2 = -2, S=1
      nxt();
      req_valid = 1'b1; req_op = 3'b110; req_s = 1'b1;
      req_rm = 32'hFFFF_FFFF; req_rs = 2; req_acc_hi = 0; req_acc_lo = 0;
      req_rd_lo = 4; req_rd_hi = 5;
      nxt();
      req_valid = 1'b0;
      #1;
      chk("smull_start", mul_start, 1);
      chk("smull_sig", mul_sig, 1);
      chk("smull_qsize", mul_q_size, 1);
      chk("smull_add", mul_add, 0);
      nxt();
      mul_rdy = 1'b1; mul_q_hi = 32'hFFFF_FFFF; mul_q_lo = 32'hFFFF_FFFE;
      nxt();
      mul_rdy = 1'b0;
      #1;
      chk("smull_lo_en", wr_en, 1);
      chk("smull_lo_reg", wr_reg, 4);
      chk("smull_lo_val", wr_value, 32'hFFFF_FFFE);
      chk("smull_lo_fwe", flags_we, 0);
      nxt();
      #1;
      chk("smull_hi_en", wr_en, 1);
      chk("smull_hi_reg", wr_reg, 5);
      chk("smull_hi_val", wr_value, 32'hFFFF_FFFF);
      chk("smull_fwe", flags_we, 1);
      chk("smull_n", flag_n, 1);
      chk("smull_z", flag_z, 0);
      nxt();
      #1 chk("smull_busy_end", busy, 0);

      // UMLAL 1*1 + 0x1_FFFFFFFF, with wr_ready low 5 cycles in WB_LO
      nxt();
      req_valid = 1'b1; req_op = 3'b101; req_s = 1'b0;
      req_rm = 1; req_rs = 1; req_acc_hi = 1; req_acc_lo = 32'hFFFF_FFFF;
      req_rd_lo = 6; req_rd_hi = 7;
      nxt();
      req_valid = 1'b0;
      #1;
      chk("umlal_csize", mul_c_size, 1);
      chk("umlal_add", mul_add, 1);
      chk("umlal_sig", mul_sig, 0);
      chk("umlal_c_hi", mul_c_hi, 1);
      chk("umlal_c_lo", mul_c_lo, 32'hFFFF_FFFF);
      nxt();
      mul_rdy = 1'b1; mul_q_hi = 2; mul_q_lo = 0; wr_ready = 1'b0;
      nxt();
      mul_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_en", wr_en, 1);
         chk("stall_reg", wr_reg, 6);
         chk("stall_val", wr_value, 0);
         nxt();
      end
      wr_ready = 1'b1;
      #1;
      chk("umlal_lo_reg", wr_reg, 6);
      chk("umlal_lo_val", wr_value, 0);
      nxt();
      #1;
      chk("umlal_hi_en", wr_en, 1);
      chk("umlal_hi_reg", wr_reg, 7);
      chk("umlal_hi_val", wr_value, 2);
      chk("umlal_fwe", flags_we, 0);
      nxt();
      #1 chk("umlal_busy_end", busy, 0);

      // flush two cycles after mul_start -> DRAIN, late result dropped
      nxt();
      req_valid = 1'b1; req_op = 3'b000; req_s = 1'b1;
      req_rm = 3; req_rs = 3; req_acc_lo = 0; req_rd_lo = 8;
      nxt();
      req_valid = 1'b0;
      #1 chk("fl_start", mul_start, 1);
      nxt();
      nxt();
      flush = 1'b1;
      #1 chk("fl_wr0", wr_en, 0);
      nxt();
      flush = 1'b0; req_valid = 1'b1;
      #1;
      chk("fl_busy", busy, 1);
      chk("fl_ready", req_ready, 0);
      req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         nxt();
         #1 chk("drain_wr", wr_en, 0);
      end
      nxt();
      mul_rdy = 1'b1; mul_q_lo = 9;
      #1;
      chk("drain_rdy_wr", wr_en, 0);
      chk("drain_rdy_busy", busy, 1);
      nxt();
      mul_rdy = 1'b0;
      #1;
      chk("drain_ready", req_ready, 1);
      chk("drain_busy", busy, 0);
      chk("drain_wr_end", wr_en, 0);
      nxt();
      #1 chk("drain_late_wr", wr_en, 0);

      // flush during WB_LO kills the write and the flags
      nxt();
      req_valid = 1'b1; req_op = 3'b000; req_s = 1'b1;
      req_rm = 2; req_rs = 0; req_rd_lo = 2;
      nxt();
      req_valid = 1'b0;
      nxt();
      mul_rdy = 1'b1; mul_q_hi = 0; mul_q_lo = 0;
      nxt();
      mul_rdy = 1'b0; flush = 1'b1;
      #1;
      chk("wbfl_wr", wr_en, 0);
      chk("wbfl_fwe", flags_we, 0);
      nxt();
      flush = 1'b0;
      #1;
      chk("wbfl_busy", busy, 0);
      chk("wbfl_wr_after", wr_en, 0);

      // timeout: no mul_rdy
      nxt();
      req_valid = 1'b1; req_op = 3'b000; req_s = 1'b0;
      req_rm = 5; req_rs = 5;
      nxt();
      req_valid = 1'b0;
      #1 chk("to_start", mul_start, 1);
      for (int i = 1; i < MAX_CYC; i++) begin
         nxt();
         #1;
         chk("to_err_early", err, 0);
         chk("to_busy", busy, 1);
      end
      nxt();
      #1;
      chk("to_err", err, 1);
      chk("to_idle", busy, 0);
      nxt();
      #1 chk("to_err_pulse", err, 0);

      // illegal op 010
      nxt();
      req_valid = 1'b1; req_op = 3'b010;
      #1 chk("ill_ready", req_ready, 1);
      nxt();
      req_valid = 1'b0;
      #1;
      chk("ill_err", err, 1);
      chk("ill_start", mul_start, 0);
      chk("ill_busy", busy, 0);
      nxt();
      #1;
      chk("ill_err_pulse", err, 0);
      chk("ill_no_start", mul_start, 0);

      // asynchronous reset in ISSUE
      nxt();
      req_valid = 1'b1; req_op = 3'b000; req_rm = 11; req_rs = 1;
      nxt();
      req_valid = 1'b0;
      #1 chk("ar_start", mul_start, 1);
      rst = 1'b1;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_start_off", mul_start, 0);
      chk("ar_mul_a", mul_a, 0);
      nxt();
      rst = 1'b0;
      nxt();
      #1 chk("ar_ready", req_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
